// File: rtl/dsi_pkg.sv
// Shared constants for the DSI lane receiver: default sync byte, LP line codes and FSM encoding.
package dsi_pkg;

    typedef logic [7:0] lane_byte_t;
    typedef logic [1:0] lp_code_t;

    localparam lane_byte_t SYNC_PATTERN_DEFAULT = 8'b00011101;

    localparam lp_code_t LP_STOP     = 2'b11;
    localparam lp_code_t LP_HS_RQST  = 2'b01;
    localparam lp_code_t LP_BRIDGE   = 2'b00;
    localparam lp_code_t LP_ESC_RQST = 2'b10;

    localparam logic [2:0] ST_STOP      = 3'd0;
    localparam logic [2:0] ST_HS_RQST   = 3'd1;
    localparam logic [2:0] ST_SYNC_HUNT = 3'd2;
    localparam logic [2:0] ST_RECEIVE   = 3'd3;
    localparam logic [2:0] ST_WAIT_STOP = 3'd4;

    // True when v has at most one bit set.
    function automatic logic at_most_one_set(input lane_byte_t v);
        return (v & (v - 8'd1)) == 8'd0;
    endfunction

endpackage

// File: rtl/dsi_lane_rx_if.sv
// Lane-side and link-side signals of the DSI lane receiver, bundled for the top-level port.
interface dsi_lane_rx_if;
    logic       rx_enable;
    logic       lp_in_p;
    logic       lp_in_n;
    logic [7:0] hs_byte_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       sop;
    logic       eot;
    logic       active;
    logic [2:0] align_offset;
    logic       sync_error;
    logic       lp_seq_error;
    logic       sot_err_corrected;

    modport master (
        output rx_enable, lp_in_p, lp_in_n, hs_byte_in,
        input  data_out, data_valid, sop, eot, active, align_offset,
               sync_error, lp_seq_error, sot_err_corrected
    );

    modport slave (
        input  rx_enable, lp_in_p, lp_in_n, hs_byte_in,
        output data_out, data_valid, sop, eot, active, align_offset,
               sync_error, lp_seq_error, sot_err_corrected
    );
endinterface

// File: rtl/dsi_sync_aligner.sv
// Sync-byte hunter and bit-alignment mux over a 16-bit window of two consecutive raw bytes.
// DSI_LANE_RX_SOT_ECC_EN additionally accepts a candidate one bit away from the sync byte.
module dsi_sync_aligner
    import dsi_pkg::*;
#(
    parameter lane_byte_t SYNC_PATTERN = SYNC_PATTERN_DEFAULT
) (
    input  logic       clk_base,
    input  logic [7:0] hs_byte_in,
    input  logic [2:0] sel,
    output logic       found,
    output logic [2:0] found_k,
    output logic       found_corr,
    output logic [7:0] sel_byte
);

    logic [7:0]  prev_byte_p0;
    logic [15:0] window;

    always_ff @(posedge clk_base)
        prev_byte_p0 <= hs_byte_in;

    assign window   = {hs_byte_in, prev_byte_p0};
    assign sel_byte = window[sel +: 8];

    // Scan from the highest offset down so the lowest matching offset is the one kept.
    always_comb begin
        found      = 1'b0;
        found_k    = 3'd0;
        found_corr = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            if (window[k +: 8] == SYNC_PATTERN) begin
                found   = 1'b1;
                found_k = 3'(k);
            end
        end
`ifdef DSI_LANE_RX_SOT_ECC_EN
        if (!found) begin
            for (int k = 7; k >= 0; k--) begin
                if (at_most_one_set(window[k +: 8] ^ SYNC_PATTERN)) begin
                    found      = 1'b1;
                    found_k    = 3'(k);
                    found_corr = 1'b1;
                end
            end
        end
`endif
    end

endmodule

// File: rtl/dsi_lane_rx.sv
// DSI data-lane receiver: LP sequence tracking, HS sync hunt, bit alignment and trail-byte delay line.
// DSI_LANE_RX_SOT_ECC_EN enables single-bit-error tolerant sync detection (see dsi_sync_aligner).
module dsi_lane_rx
    import dsi_pkg::*;
#(
    parameter lane_byte_t SYNC_PATTERN = SYNC_PATTERN_DEFAULT,
    parameter int         SYNC_TIMEOUT = 32,
    parameter int         TRAIL_DEPTH  = 4
) (
    input  logic         clk_base,
    input  logic         reset,
    dsi_lane_rx_if.slave lane
);

    localparam int CNT_W  = $clog2(SYNC_TIMEOUT + 1);
    localparam int DCNT_W = $clog2(TRAIL_DEPTH + 1);

    logic [1:0]        lp_sync_p0, lp_sync_p1, lp_sync_p2, lp_filt;
    logic [2:0]        state;
    logic [CNT_W-1:0]  hunt_cnt;
    logic [DCNT_W-1:0] dcnt;
    logic              sop_pend, corr_lat, push;
    logic              found, found_corr;
    logic [2:0]        found_k;
    logic [7:0]        cand;
    logic [7:0]        dline [TRAIL_DEPTH];

    dsi_sync_aligner #(.SYNC_PATTERN(SYNC_PATTERN)) u_aligner (
        .clk_base   (clk_base),
        .hs_byte_in (lane.hs_byte_in),
        .sel        (lane.align_offset),
        .found      (found),
        .found_k    (found_k),
        .found_corr (found_corr),
        .sel_byte   (cand)
    );

    // LP comparators: two-flop synchronizer, then accept only a value seen on two consecutive cycles.
    always_ff @(posedge clk_base or posedge reset) begin
        if (reset) begin
            lp_sync_p0 <= LP_STOP;
            lp_sync_p1 <= LP_STOP;
            lp_sync_p2 <= LP_STOP;
            lp_filt    <= LP_STOP;
        end else begin
            lp_sync_p0 <= {lane.lp_in_p, lane.lp_in_n};
            lp_sync_p1 <= lp_sync_p0;
            lp_sync_p2 <= lp_sync_p1;
            if (lp_sync_p1 == lp_sync_p2)
                lp_filt <= lp_sync_p1;
        end
    end

    assign push        = lane.rx_enable && (state == ST_RECEIVE) && (lp_filt != LP_STOP);
    assign lane.active = (state != ST_STOP);

    always_ff @(posedge clk_base) begin
        if (push) begin
            dline[0] <= cand;
            for (int i = 1; i < TRAIL_DEPTH; i++)
                dline[i] <= dline[i-1];
        end
    end

    always_ff @(posedge clk_base or posedge reset) begin
        if (reset) begin
            state                  <= ST_STOP;
            hunt_cnt               <= '0;
            dcnt                   <= '0;
            sop_pend               <= 1'b0;
            corr_lat               <= 1'b0;
            lane.align_offset      <= 3'd0;
            lane.data_out          <= 8'd0;
            lane.data_valid        <= 1'b0;
            lane.sop               <= 1'b0;
            lane.eot               <= 1'b0;
            lane.sync_error        <= 1'b0;
            lane.lp_seq_error      <= 1'b0;
            lane.sot_err_corrected <= 1'b0;
        end else begin
            lane.data_valid        <= 1'b0;
            lane.sop               <= 1'b0;
            lane.eot               <= 1'b0;
            lane.sync_error        <= 1'b0;
            lane.lp_seq_error      <= 1'b0;
            lane.sot_err_corrected <= 1'b0;
            if (!lane.rx_enable) begin
                // Silent abort: no eot or error, buffered bytes are dropped.
                if (state != ST_STOP)
                    state <= ST_WAIT_STOP;
                dcnt <= '0;
            end else begin
                case (state)
                    ST_STOP: begin
                        case (lp_filt)
                            LP_HS_RQST:  state <= ST_HS_RQST;
                            LP_BRIDGE: begin
                                lane.lp_seq_error <= 1'b1;
                                state             <= ST_WAIT_STOP;
                            end
                            LP_ESC_RQST: state <= ST_WAIT_STOP;
                            default: ;
                        endcase
                    end
                    ST_HS_RQST: begin
                        case (lp_filt)
                            LP_BRIDGE: begin
                                state    <= ST_SYNC_HUNT;
                                hunt_cnt <= '0;
                            end
                            LP_STOP: begin
                                lane.lp_seq_error <= 1'b1;
                                state             <= ST_STOP;
                            end
                            LP_ESC_RQST: begin
                                lane.lp_seq_error <= 1'b1;
                                state             <= ST_WAIT_STOP;
                            end
                            default: ;
                        endcase
                    end
                    ST_SYNC_HUNT: begin
                        if (lp_filt == LP_STOP) begin
                            lane.sync_error <= 1'b1;
                            state           <= ST_STOP;
                        end else if (found) begin
                            state             <= ST_RECEIVE;
                            lane.align_offset <= found_k;
                            corr_lat          <= found_corr;
                            sop_pend          <= 1'b1;
                            dcnt              <= '0;
                        end else if (hunt_cnt == CNT_W'(SYNC_TIMEOUT - 1)) begin
                            lane.sync_error <= 1'b1;
                            state           <= ST_WAIT_STOP;
                        end else begin
                            hunt_cnt <= hunt_cnt + CNT_W'(1);
                        end
                    end
                    ST_RECEIVE: begin
                        if (lp_filt == LP_STOP) begin
                            lane.eot <= 1'b1;
                            dcnt     <= '0;
                            state    <= ST_STOP;
                        end else if (dcnt == DCNT_W'(TRAIL_DEPTH)) begin
                            lane.data_out          <= dline[TRAIL_DEPTH-1];
                            lane.data_valid        <= 1'b1;
                            lane.sop               <= sop_pend;
                            lane.sot_err_corrected <= sop_pend & corr_lat;
                            sop_pend               <= 1'b0;
                        end else begin
                            dcnt <= dcnt + DCNT_W'(1);
                        end
                    end
                    ST_WAIT_STOP: begin
                        if (lp_filt == LP_STOP)
                            state <= ST_STOP;
                    end
                    default: state <= ST_STOP;
                endcase
            end
        end
    end

endmodule
